// File: rtl/conversor_bcd_display_pkg.sv
// rtl/conversor_bcd_display_pkg.sv - shared types and constants for the BCD display converter
package conversor_bcd_display_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DESLOCA,
        CONCLUI
    } estado_t;

    // Active-low segments, bit0 = a .. bit6 = g
    localparam logic [6:0] SEG_0       = 7'h40;
    localparam logic [6:0] SEG_1       = 7'h79;
    localparam logic [6:0] SEG_2       = 7'h24;
    localparam logic [6:0] SEG_3       = 7'h30;
    localparam logic [6:0] SEG_4       = 7'h19;
    localparam logic [6:0] SEG_5       = 7'h12;
    localparam logic [6:0] SEG_6       = 7'h02;
    localparam logic [6:0] SEG_7       = 7'h78;
    localparam logic [6:0] SEG_8       = 7'h00;
    localparam logic [6:0] SEG_9       = 7'h10;
    localparam logic [6:0] SEG_APAGADO = 7'h7F;
    localparam logic [6:0] SEG_TRACO   = 7'h3F;

    function automatic int pot10(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

endpackage

// File: rtl/conversor_bcd_display_if.sv
// rtl/conversor_bcd_display_if.sv - start/pronto handshake and display outputs bundle
interface conversor_bcd_display_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    logic                  start;
    logic [WIDTH-1:0]      valor;
    logic                  ocupado;
    logic                  pronto;
    logic                  estouro;
    logic [4*DIGITS-1:0]   bcd;
    logic [7*DIGITS-1:0]   seg;

    modport master (
        output start, valor,
        input  ocupado, pronto, estouro, bcd, seg
    );

    modport slave (
        input  start, valor,
        output ocupado, pronto, estouro, bcd, seg
    );
endinterface

// File: rtl/conversor_bcd_display_decodificador_7seg.sv
// rtl/conversor_bcd_display_decodificador_7seg.sv - BCD digit to active-low 7-segment decoder
module decodificador_7seg
    import conversor_bcd_display_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);
    always_comb begin
        seg_o = SEG_APAGADO;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_APAGADO;
        endcase
    end
endmodule

// File: rtl/conversor_bcd_display.sv
// rtl/conversor_bcd_display.sv - iterative double-dabble binary to BCD converter driving 7-segment displays
module conversor_bcd_display
    import conversor_bcd_display_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int DIGITS        = 3,
    parameter int SUPRIME_ZEROS = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    conversor_bcd_display_if.slave  bus
);
    localparam int          SW     = 4 * DIGITS;
    localparam int          CW     = $clog2(WIDTH + 1);
    localparam logic [31:0] LIMITE = 32'(pot10(DIGITS));

    estado_t               estado_q, estado_d;
    logic [WIDTH-1:0]      desloc_q, desloc_d;
    logic [SW-1:0]         scratch_q, scratch_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  ovf_q, ovf_d;
    logic [SW-1:0]         bcd_q, bcd_d;
    logic [7*DIGITS-1:0]   seg_q, seg_d;
    logic                  estouro_q, estouro_d;
    logic                  pronto_q, pronto_d;

    logic [SW-1:0]         ajustado;
    logic [7*DIGITS-1:0]   seg_dec;
    logic                  zeros_acima;

    for (genvar k = 0; k < DIGITS; k++) begin : g_dec
        decodificador_7seg u_dec (
            .bcd_i (scratch_q[4*k +: 4]),
            .seg_o (seg_dec[7*k +: 7])
        );
    end

    always_comb begin
        estado_d    = estado_q;
        desloc_d    = desloc_q;
        scratch_d   = scratch_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        bcd_d       = bcd_q;
        seg_d       = seg_q;
        estouro_d   = estouro_q;
        pronto_d    = 1'b0;
        zeros_acima = 1'b1;

        ajustado = scratch_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (scratch_q[4*k +: 4] >= 4'd5)
                ajustado[4*k +: 4] = scratch_q[4*k +: 4] + 4'd3;
        end

        case (estado_q)
            IDLE: begin
                if (bus.start) begin
                    desloc_d  = bus.valor;
                    scratch_d = '0;
                    cnt_d     = CW'(WIDTH);
                    ovf_d     = ({{(32-WIDTH){1'b0}}, bus.valor} >= LIMITE);
                    estado_d  = DESLOCA;
                end
            end
            DESLOCA: begin
                {scratch_d, desloc_d} = {ajustado[SW-2:0], desloc_q, 1'b0};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1))
                    estado_d = CONCLUI;
            end
            CONCLUI: begin
                pronto_d  = 1'b1;
                estado_d  = IDLE;
                estouro_d = ovf_q;
                if (ovf_q) begin
                    bcd_d = '0;
                    seg_d = {DIGITS{SEG_TRACO}};
                end else begin
                    bcd_d = scratch_q;
                    seg_d = seg_dec;
                    // Blank from the top down until the first non-zero digit; digit 0 always shows
                    if (SUPRIME_ZEROS != 0) begin
                        for (int k = DIGITS - 1; k >= 1; k--) begin
                            if (zeros_acima && (scratch_q[4*k +: 4] == 4'd0))
                                seg_d[7*k +: 7] = SEG_APAGADO;
                            else
                                zeros_acima = 1'b0;
                        end
                    end
                end
            end
            default: estado_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q  <= IDLE;
            desloc_q  <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            bcd_q     <= '0;
            seg_q     <= '1;
            estouro_q <= 1'b0;
            pronto_q  <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            desloc_q  <= desloc_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            bcd_q     <= bcd_d;
            seg_q     <= seg_d;
            estouro_q <= estouro_d;
            pronto_q  <= pronto_d;
        end
    end

    assign bus.ocupado = (estado_q == DESLOCA);
    assign bus.pronto  = pronto_q;
    assign bus.estouro = estouro_q;
    assign bus.bcd     = bcd_q;
    assign bus.seg     = seg_q;

endmodule

// File: tb/tb_conversor_bcd_display.sv
// tb/tb_conversor_bcd_display.sv - directed self-checking bench for conversor_bcd_display
module tb_conversor_bcd_display;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int lat;
    int npronto;

    conversor_bcd_display_if #(.WIDTH(8), .DIGITS(3)) if_a ();
    conversor_bcd_display_if #(.WIDTH(8), .DIGITS(3)) if_b ();
    conversor_bcd_display_if #(.WIDTH(8), .DIGITS(2)) if_c ();

    conversor_bcd_display #(.WIDTH(8), .DIGITS(3), .SUPRIME_ZEROS(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(if_a)
    );
    conversor_bcd_display #(.WIDTH(8), .DIGITS(3), .SUPRIME_ZEROS(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(if_b)
    );
    conversor_bcd_display #(.WIDTH(8), .DIGITS(2), .SUPRIME_ZEROS(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .bus(if_c)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Edges counted after the accepting edge until pronto is seen; -1 if it never comes
    task automatic espera_pronto(output int n);
        n = -1;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (if_a.pronto === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic converte(input logic [7:0] v, input string tag);
        int n;
        @(negedge clk);
        if_a.start = 1'b1; if_a.valor = v;
        if_b.start = 1'b1; if_b.valor = v;
        if_c.start = 1'b1; if_c.valor = v;
        @(posedge clk);
        #1;
        if_a.start = 1'b0; if_b.start = 1'b0; if_c.start = 1'b0;
        @(negedge clk);
        chk({tag, "_ocupado"}, 64'(if_a.ocupado), 64'd1);
        espera_pronto(n);
        chk({tag, "_latencia"}, 64'(n), 64'd9);
        chk({tag, "_ocupado_fim"}, 64'(if_a.ocupado), 64'd0);
        @(negedge clk);
        chk({tag, "_pronto_pulso"}, 64'(if_a.pronto), 64'd0);
    endtask

    initial begin
        if_a.start = 1'b0; if_a.valor = '0;
        if_b.start = 1'b0; if_b.valor = '0;
        if_c.start = 1'b0; if_c.valor = '0;

        #2 rst_n = 1'b0;
        #1;
        chk("rst_ocupado", 64'(if_a.ocupado), 64'd0);
        chk("rst_pronto",  64'(if_a.pronto),  64'd0);
        chk("rst_estouro", 64'(if_a.estouro), 64'd0);
        chk("rst_bcd",     64'(if_a.bcd),     64'h000);
        chk("rst_seg",     64'(if_a.seg),     64'h1FFFFF);
        chk("rst_seg_c",   64'(if_c.seg),     64'h3FFF);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        converte(8'd255, "v255");
        chk("v255_bcd",     64'(if_a.bcd),     64'h255);
        chk("v255_seg",     64'(if_a.seg),     64'({7'h24, 7'h12, 7'h12}));
        chk("v255_estouro", 64'(if_a.estouro), 64'd0);
        chk("v255_c_est",   64'(if_c.estouro), 64'd1);
        chk("v255_c_bcd",   64'(if_c.bcd),     64'h00);
        chk("v255_c_seg",   64'(if_c.seg),     64'({7'h3F, 7'h3F}));

        converte(8'd7, "v7");
        chk("v7_bcd",   64'(if_a.bcd), 64'h007);
        chk("v7_seg",   64'(if_a.seg), 64'({7'h7F, 7'h7F, 7'h78}));
        chk("v7_seg_b", 64'(if_b.seg), 64'({7'h40, 7'h40, 7'h78}));

        converte(8'd0, "v0");
        chk("v0_bcd", 64'(if_a.bcd), 64'h000);
        chk("v0_seg", 64'(if_a.seg), 64'({7'h7F, 7'h7F, 7'h40}));

        converte(8'd100, "v100");
        chk("v100_bcd",   64'(if_a.bcd),     64'h100);
        chk("v100_seg",   64'(if_a.seg),     64'({7'h79, 7'h40, 7'h40}));
        chk("v100_c_est", 64'(if_c.estouro), 64'd1);
        chk("v100_c_bcd", 64'(if_c.bcd),     64'h00);
        chk("v100_c_seg", 64'(if_c.seg),     64'({7'h3F, 7'h3F}));

        converte(8'd99, "v99");
        chk("v99_c_bcd", 64'(if_c.bcd),     64'h99);
        chk("v99_c_est", 64'(if_c.estouro), 64'd0);
        chk("v99_c_seg", 64'(if_c.seg),     64'({7'h10, 7'h10}));

        // start held high: second request accepted only after the first pronto
        @(negedge clk);
        if_a.start = 1'b1; if_a.valor = 8'd31;
        @(posedge clk);
        #1 if_a.valor = 8'd13;
        espera_pronto(lat);
        chk("b2b1_latencia", 64'(lat), 64'd9);
        chk("b2b1_bcd", 64'(if_a.bcd), 64'h031);
        chk("b2b1_seg", 64'(if_a.seg), 64'({7'h7F, 7'h30, 7'h79}));
        @(posedge clk);
        #1;
        if_a.valor = 8'd99;
        if_a.start = 1'b0;
        espera_pronto(lat);
        chk("b2b2_intervalo", 64'(lat), 64'd9);
        chk("b2b2_bcd", 64'(if_a.bcd), 64'h013);
        chk("b2b2_seg", 64'(if_a.seg), 64'({7'h7F, 7'h79, 7'h30}));

        // asynchronous reset in the middle of a conversion
        @(negedge clk);
        if_a.start = 1'b1; if_a.valor = 8'd200;
        @(posedge clk);
        #1 if_a.start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rstm_ocupado", 64'(if_a.ocupado), 64'd0);
        chk("rstm_pronto",  64'(if_a.pronto),  64'd0);
        chk("rstm_estouro", 64'(if_a.estouro), 64'd0);
        chk("rstm_bcd",     64'(if_a.bcd),     64'h000);
        chk("rstm_seg",     64'(if_a.seg),     64'h1FFFFF);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        npronto = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (if_a.pronto !== 1'b0) npronto++;
        end
        chk("rstm_sem_pronto", 64'(npronto), 64'd0);

        converte(8'd42, "v42");
        chk("v42_bcd", 64'(if_a.bcd), 64'h042);
        chk("v42_seg", 64'(if_a.seg), 64'({7'h7F, 7'h19, 7'h24}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
